// File: rtl/pattern_player.sv
// pattern_player: plays a DEPTH x DW pattern memory over a valid/ready stream; PLAYER_LOOP_EN adds the loop port
module pattern_player #(
  parameter int DW = 8,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] last_idx,
`ifdef PLAYER_LOOP_EN
  input  logic          loop,
`endif
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          busy,
  output logic          done
);
  typedef enum logic {IDLE, PLAY} state_t;
  state_t state, state_n;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] data_n;
  logic [AW-1:0] last, last_n, addr_n, nxt;
  logic loop_r, loop_n, loop_in, done_n, fire;
`ifdef PLAYER_LOOP_EN
  assign loop_in = loop;
`else
  assign loop_in = 1'b0;
`endif
  assign out_valid = state == PLAY;
  assign busy = state == PLAY;
  assign fire = out_valid & out_ready;
  assign nxt = out_addr + AW'(1);
  // pattern memory is writable only while idle and is never cleared
  always_ff @(posedge clk)
    if (wr_en && state == IDLE) mem[wr_addr] <= wr_data;
  // state and output registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      out_data <= '0;
      out_addr <= '0;
      last <= '0;
      loop_r <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      out_data <= data_n;
      out_addr <= addr_n;
      last <= last_n;
      loop_r <= loop_n;
      done <= done_n;
    end
  // next state: start loads entry 0, each transfer advances, stop aborts without done
  always_comb begin
    state_n = state;
    data_n = out_data;
    addr_n = out_addr;
    last_n = last;
    loop_n = loop_r;
    done_n = 1'b0;
    if (state == IDLE) begin
      if (start) begin
        state_n = PLAY;
        addr_n = '0;
        data_n = mem[0];
        last_n = last_idx;
        loop_n = loop_in;
      end
    end else if (stop) begin
      state_n = IDLE;
    end else if (fire) begin
      if (out_addr != last) begin
        addr_n = nxt;
        data_n = mem[nxt];
      end else if (loop_r) begin
        addr_n = '0;
        data_n = mem[0];
      end else begin
        state_n = IDLE;
        done_n = 1'b1;
      end
    end
  end
endmodule

// File: doc/pattern_player.md
Name: pattern_player

Overview:
- Sequencer that owns a DEPTH x DW pattern memory and plays it out, one entry per transfer, over a valid/ready stream.
- Host loads entries through a write port, then pulses start with a last-index value. The block steps the address, handshakes each word and signals completion.
- Sits between a test/stimulus source and any datapath consuming an 8-bit sample stream. It is the RTL counterpart of stepping a preloaded memory one entry per cycle.

Parameters:
- DW, 8, data width of each pattern entry
- DEPTH, 16, number of memory entries
- AW, 4, address width; must satisfy 2**AW == DEPTH

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write strobe for pattern memory
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- last_idx  in  AW  index of final entry to play; sampled on accepted start
- loop  in  1  wrap to entry 0 after last_idx; only present/used with PLAYER_LOOP_EN, see below
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  consumer accepts current word
- out_data  out  DW  current pattern entry
- out_addr  out  AW  index of current entry
- busy  out  1  high while in PLAY
- done  out  1  one-cycle pulse after final entry transferred

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE; out_valid=0, out_data=0, out_addr=0, busy=0, done=0.
  - Memory contents are not cleared.
- Memory:
  - Register array; write on edge when wr_en=1 and state=IDLE.
  - wr_en in PLAY is ignored; no write occurs.
- States: IDLE, PLAY.
- IDLE -> PLAY on start=1:
  - Latch last_idx (and loop).
  - Next cycle: out_valid=1, out_addr=0, out_data=mem[0], busy=1.
  - If wr_en and start occur in the same cycle, the start-edge read returns the pre-write contents.
- Handshake:
  - A transfer occurs on an edge where out_valid=1 and out_ready=1.
  - out_data/out_addr remain stable while out_valid=1 and out_ready=0.
  - Transfer of entry k<last_idx: next cycle out_addr=k+1, out_data=mem[k+1], out_valid stays 1. This gives full throughput of one word per cycle with out_ready held high.
  - Transfer of entry k==last_idx, no loop: next cycle out_valid=0, busy=0, done=1 for exactly one cycle, state=IDLE. out_data/out_addr hold their last values.
- last_idx=0: plays exactly one entry.
- last_idx=DEPTH-1: addresses 0..DEPTH-1; the address counter wraps naturally only in loop mode.
- start while in PLAY is ignored.
- stop:
  - In PLAY, stop=1 forces state=IDLE at that edge: out_valid=0, busy=0, done stays 0.
  - stop wins over a simultaneous handshake. The word counts as transferred on the consumer side, but no done is generated.
  - stop in IDLE has no effect; start+stop in IDLE starts playback.
- rst mid-PLAY: immediate return to reset values, no done.
- Latency: start edge to first out_valid = 1 cycle; final handshake edge to done = 1 cycle.

Optional Feature:
- Macro: PLAYER_LOOP_EN.
- Defined:
  - loop port exists and is sampled with last_idx on start.
  - If loop=1, the transfer of last_idx returns to out_addr=0, out_data=mem[0] with out_valid still 1.
  - done is never pulsed; playback ends only via stop or rst.
- Undefined:
  - loop port absent.
  - Playback always terminates after last_idx with a done pulse.

Test Plan:
- Reset/idle: load mem[i]=i+8'h10 for i=0..15; assert rst -> out_valid=0, busy=0, done=0, out_data=0, out_addr=0.
- Full playback: start with last_idx=15 and out_ready held 1 -> out_data 10,11,...,1F on 16 consecutive cycles; done=1 on the cycle after 1F transfers; busy=0 afterwards.
- Backpressure: last_idx=3, out_ready toggled 1,0,0,1,... -> each of 10..13 is held stable while ready=0, every word is transferred exactly once in order, and there is one done pulse.
- Boundary: last_idx=0 -> single word 10 then done; a wr_en to addr 2 during PLAY leaves mem[2]=12 on a subsequent playback.
- Abort: last_idx=15, stop asserted during the handshake of entry 5 -> out_valid=0 next cycle and done never asserts; a subsequent start replays from 10.
- Loop (PLAYER_LOOP_EN defined): loop=1, last_idx=2 -> stream 10,11,12,10,11,12,... with no done; stop ends it with out_valid=0.
